// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, index/word types and the $zero index
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback and ID read-port bundle for wb_regfile
interface wb_regfile_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 32
);

  logic              RegWrite_in;
  logic              MemtoReg_in;
  logic [DATA_W-1:0] RD_in;
  logic [DATA_W-1:0] ALU_in;
  logic [ADDR_W-1:0] WN_in;
  logic [ADDR_W-1:0] RN1;
  logic [ADDR_W-1:0] RN2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] WD_out;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output RegWrite_in, MemtoReg_in, RD_in, ALU_in, WN_in, RN1, RN2,
    input  RD1, RD2, WD_out, wb_count
  );

  modport slave (
    input  RegWrite_in, MemtoReg_in, RD_in, ALU_in, WN_in, RN1, RN2,
    output RD1, RD2, WD_out, wb_count
  );

endinterface

// File: rtl/wb_regfile_mux.sv
// rtl/wb_regfile_mux.sv - 2:1 writeback data select (memory data vs ALU result)
module wb_mux #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] wd
);

  // Loads write back memory data, everything else writes back the ALU result
  always_comb begin
    wd = mem_to_reg ? rd_data : alu_data;
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with two read ports and retired-write counter (optional WB_BYPASS_EN write-through)
module wb_regfile #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREGS  = 2**ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wd;
  logic              commit;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .mem_to_reg (bus.MemtoReg_in),
    .rd_data    (bus.RD_in),
    .alu_data   (bus.ALU_in),
    .wd         (wd)
  );

  // A write retires only when enabled, not aimed at $zero and not swallowed by reset
  always_comb begin
    commit = bus.RegWrite_in && (bus.WN_in != ADDR_W'(REG_ZERO)) && !rst;
  end

  // Register array: reset clears every entry, otherwise commit one write per edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[bus.WN_in] <= wd;
    end
  end

  // Retired-write counter; wraps silently, a held stall input counts every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (commit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Read ports: $zero and reset read as zero; optional same-cycle write-through
  always_comb begin
    rd1 = regs[bus.RN1];
    rd2 = regs[bus.RN2];
`ifdef WB_BYPASS_EN
    if (commit && (bus.RN1 == bus.WN_in)) rd1 = wd;
    if (commit && (bus.RN2 == bus.WN_in)) rd2 = wd;
`endif
    if (rst || (bus.RN1 == ADDR_W'(REG_ZERO))) rd1 = '0;
    if (rst || (bus.RN2 == ADDR_W'(REG_ZERO))) rd2 = '0;
  end

  assign bus.RD1      = rd1;
  assign bus.RD2      = rd2;
  assign bus.WD_out   = wd;
  assign bus.wb_count = cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile (directed + random, honours WB_BYPASS_EN)
module tb_wb_regfile;

  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3))  bus_w ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .CNT_W(3)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [32];
  logic [31:0] model_cnt;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input bit in_rst,
                                           input bit wr, input logic [4:0] wn,
                                           input logic [31:0] wd);
    if (in_rst || idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wr && wn != 5'd0 && idx == wn) return wd;
`endif
    return model[idx];
  endfunction

  task automatic step(input bit r, input bit w, input bit mtr,
                      input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wn, input logic [4:0] rn1, input logic [4:0] rn2);
    logic [31:0] wd_exp;
    @(negedge clk);
    rst = r;
    bus.RegWrite_in = w;   bus_w.RegWrite_in = w;
    bus.MemtoReg_in = mtr; bus_w.MemtoReg_in = mtr;
    bus.RD_in = rd;        bus_w.RD_in = rd;
    bus.ALU_in = alu;      bus_w.ALU_in = alu;
    bus.WN_in = wn;        bus_w.WN_in = wn;
    bus.RN1 = rn1;         bus_w.RN1 = rn1;
    bus.RN2 = rn2;         bus_w.RN2 = rn2;
    #1;
    wd_exp = mtr ? rd : alu;
    chk("wd_out", bus.WD_out, wd_exp);
    chk("rd1", bus.RD1, ref_read(rn1, r, w, wn, wd_exp));
    chk("rd2", bus.RD2, ref_read(rn2, r, w, wn, wd_exp));
    chk("rd1_small_cnt_dut", bus_w.RD1, ref_read(rn1, r, w, wn, wd_exp));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_cnt = 32'd0;
    end else if (w && wn != 5'd0) begin
      model[wn] = wd_exp;
      model_cnt = model_cnt + 32'd1;
    end
    #1;
    chk("wb_count", bus.wb_count, model_cnt);
    chk("wb_count_mod8", {29'd0, bus_w.wb_count}, model_cnt % 32'd8);
  endtask

  initial begin
    logic [4:0] wn_r;
    errors = 0;
    checks = 0;
    model_cnt = 32'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst = 1'b1;
    bus.RegWrite_in = 0; bus.MemtoReg_in = 0; bus.RD_in = 0; bus.ALU_in = 0;
    bus.WN_in = 0; bus.RN1 = 0; bus.RN2 = 0;
    bus_w.RegWrite_in = 0; bus_w.MemtoReg_in = 0; bus_w.RD_in = 0; bus_w.ALU_in = 0;
    bus_w.WN_in = 0; bus_w.RN1 = 0; bus_w.RN2 = 0;

    // power-on reset
    step(1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd31);
    // reset clears a written register and the counter
    step(0, 1, 0, 32'd0, 32'hDEAD, 5'd5, 5'd5, 5'd0);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    chk("r5_before_reset", bus.RD1, 32'hDEAD);
    step(1, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
    chk("r5_after_reset", bus.RD1, 32'd0);
    chk("cnt_after_reset", bus.wb_count, 32'd0);
    // writeback select: memory data then ALU result
    step(0, 1, 1, 32'h1234, 32'hFFFF, 5'd3, 5'd0, 5'd0);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3);
    chk("sel_mem", bus.RD1, 32'h1234);
    chk("sel_mem_cnt", bus.wb_count, 32'd1);
    step(0, 1, 0, 32'h1234, 32'hFFFF, 5'd3, 5'd0, 5'd0);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0);
    chk("sel_alu", bus.RD1, 32'hFFFF);
    // writes to $zero are discarded
    step(0, 1, 0, 32'd0, 32'hABCD, 5'd0, 5'd0, 5'd0);
    chk("zero_cnt", bus.wb_count, 32'd2);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    chk("zero_read", bus.RD1, 32'd0);
    // same-cycle read of the write target, then next-cycle read
    step(0, 1, 0, 32'd0, 32'h55, 5'd7, 5'd7, 5'd7);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7);
    chk("r7_next", bus.RD1, 32'h55);
    // reset wins over a simultaneous write
    step(1, 1, 0, 32'd0, 32'h77, 5'd9, 5'd9, 5'd9);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
    chk("r9_dropped", bus.RD1, 32'd0);
    chk("cnt_rst_write", bus.wb_count, 32'd0);
    // counter wrap on the narrow-counter instance: eight commits return it to zero
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 32'd0, 32'h100 + i, 5'(i), 5'd0, 5'd0);
    step(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd1);
    chk("wrap_zero", {29'd0, bus_w.wb_count}, 32'd0);
    chk("wrap_data", bus_w.RD1, 32'h108);
    // held (stalled) input counts every cycle
    step(0, 1, 1, 32'hCAFE, 32'd0, 5'd12, 5'd12, 5'd0);
    step(0, 1, 1, 32'hCAFE, 32'd0, 5'd12, 5'd12, 5'd12);
    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      wn_r = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom, $urandom, wn_r,
           ($urandom_range(0, 2) == 0) ? wn_r : 5'($urandom),
           ($urandom_range(0, 2) == 0) ? wn_r : 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
